// File: rtl/wb_emem_arbiter.sv
// wb_emem_arbiter: two-master Wishbone arbiter with a per-transaction watchdog, placed in front of the SPI external-memory slave.
//  Ports:
//   clk, rst_n (async, active-low)
//   m0_*  instruction-fetch master (read-only): adr/stb/cyc in, ack/err/dat out
//   m1_*  data master (read/write): adr/dat/we/sel/stb/cyc in, ack/err/dat out
//   s_*   slave side: adr/dat/we/sel/stb/cyc out, ack/dat in
//   grant_o  one-hot owner {m1,m0}, 00 when idle
module wb_emem_arbiter #(
  parameter bit          DBUS_PRIORITY  = 1'b1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] m0_adr_i,
  input  logic        m0_stb_i,
  input  logic        m0_cyc_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,
  output logic [31:0] m0_dat_o,
  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  input  logic        m1_we_i,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_stb_i,
  input  logic        m1_cyc_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,
  output logic [31:0] m1_dat_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic        s_we_o,
  output logic [3:0]  s_sel_o,
  output logic        s_stb_o,
  output logic        s_cyc_o,
  input  logic        s_ack_i,
  input  logic [31:0] s_dat_i,
  output logic [1:0]  grant_o
);
  typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_t;
  localparam bit         WD_ON  = TIMEOUT_CYCLES != 0;
  localparam logic [7:0] T_LAST = 8'(TIMEOUT_CYCLES - 1);
  state_t     r_state, w_next;
  logic       r_last;
  logic [7:0] r_timer;
  logic       w_req0, w_req1, w_g0, w_g1, w_req, w_cyc, w_tout;
  assign w_req0 = m0_stb_i & m0_cyc_i;
  assign w_req1 = m1_stb_i & m1_cyc_i;
  assign w_g0   = r_state == GRANT0;
  assign w_g1   = r_state == GRANT1;
  assign w_req  = w_g0 ? w_req0 : w_g1 & w_req1;
  assign w_cyc  = w_g0 ? m0_cyc_i : w_g1 & m1_cyc_i;
  // An aborting master (cyc low) gets neither ack-substitute err nor timeout err.
  assign w_tout = WD_ON & w_cyc & ~s_ack_i & (r_timer == T_LAST);
  // On a tie m1 wins when prioritised, or when m0 held the last grant (r_last=0).
  always_comb begin
    w_next = r_state;
    if (r_state == IDLE)
      w_next = (w_req1 & (~w_req0 | DBUS_PRIORITY | ~r_last)) ? GRANT1 : w_req0 ? GRANT0 : IDLE;
    else
      w_next = (s_ack_i | ~w_cyc | w_tout) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= IDLE;
      r_last  <= 1'b1;
      r_timer <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_next != IDLE) begin
        r_last  <= w_next == GRANT1;
        r_timer <= '0;
      end else if ((w_g0 | w_g1) & ~s_ack_i)
        r_timer <= r_timer + 8'd1;
    end
  // Strobe is withdrawn in the ack cycle so the slave never sees a stale request.
  assign s_stb_o  = w_req & ~s_ack_i;
  assign s_cyc_o  = w_req & ~s_ack_i;
  assign s_adr_o  = w_g0 ? m0_adr_i : w_g1 ? m1_adr_i : '0;
  assign s_dat_o  = w_g1 ? m1_dat_i : '0;
  assign s_we_o   = w_g1 & m1_we_i;
  assign s_sel_o  = w_g0 ? 4'hF : w_g1 ? m1_sel_i : 4'h0;
  assign m0_ack_o = w_g0 & s_ack_i;
  assign m1_ack_o = w_g1 & s_ack_i;
  assign m0_err_o = w_g0 & w_tout;
  assign m1_err_o = w_g1 & w_tout;
  assign m0_dat_o = m0_ack_o ? s_dat_i : '0;
  assign m1_dat_o = m1_ack_o ? s_dat_i : '0;
  assign grant_o  = {w_g1, w_g0};
endmodule

// File: tb/tb_wb_emem_arbiter.sv
// tb_wb_emem_arbiter: directed bench; dut_a = priority/255 timeout, dut_b = round-robin/16 timeout, sharing inputs.
module tb_wb_emem_arbiter;
  logic clk = 0, rst_n = 0;
  logic [31:0] m0_adr, m1_adr, m1_dat, s_dat;
  logic m0_stb, m0_cyc, m1_we, m1_stb, m1_cyc, s_ack;
  logic [3:0] m1_sel;
  logic [31:0] a_s_adr, a_s_dat, a_m0_dat, a_m1_dat, b_s_adr, b_s_dat, b_m0_dat, b_m1_dat;
  logic a_s_we, a_s_stb, a_s_cyc, a_m0_ack, a_m0_err, a_m1_ack, a_m1_err;
  logic b_s_we, b_s_stb, b_s_cyc, b_m0_ack, b_m0_err, b_m1_ack, b_m1_err;
  logic [3:0] a_s_sel, b_s_sel;
  logic [1:0] a_grant, b_grant;
  int vec = 0, errs = 0;
  always #5 clk = ~clk;
  wb_emem_arbiter #(.DBUS_PRIORITY(1'b1), .TIMEOUT_CYCLES(255)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_ack_o(a_m0_ack), .m0_err_o(a_m0_err), .m0_dat_o(a_m0_dat),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_ack_o(a_m1_ack), .m1_err_o(a_m1_err), .m1_dat_o(a_m1_dat),
    .s_adr_o(a_s_adr), .s_dat_o(a_s_dat), .s_we_o(a_s_we), .s_sel_o(a_s_sel),
    .s_stb_o(a_s_stb), .s_cyc_o(a_s_cyc), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(a_grant));
  wb_emem_arbiter #(.DBUS_PRIORITY(1'b0), .TIMEOUT_CYCLES(16)) dut_b (
    .clk(clk), .rst_n(rst_n),
    .m0_adr_i(m0_adr), .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc),
    .m0_ack_o(b_m0_ack), .m0_err_o(b_m0_err), .m0_dat_o(b_m0_dat),
    .m1_adr_i(m1_adr), .m1_dat_i(m1_dat), .m1_we_i(m1_we), .m1_sel_i(m1_sel),
    .m1_stb_i(m1_stb), .m1_cyc_i(m1_cyc),
    .m1_ack_o(b_m1_ack), .m1_err_o(b_m1_err), .m1_dat_o(b_m1_dat),
    .s_adr_o(b_s_adr), .s_dat_o(b_s_dat), .s_we_o(b_s_we), .s_sel_o(b_s_sel),
    .s_stb_o(b_s_stb), .s_cyc_o(b_s_cyc), .s_ack_i(s_ack), .s_dat_i(s_dat),
    .grant_o(b_grant));
  task automatic clear_inputs;
    m0_adr = 0; m0_stb = 0; m0_cyc = 0;
    m1_adr = 0; m1_dat = 0; m1_we = 0; m1_sel = 0; m1_stb = 0; m1_cyc = 0;
    s_ack = 0; s_dat = 0;
  endtask
  task automatic do_reset;
    clear_inputs();
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask
  task automatic test_reset;
    logic [140:0] all_a;
    clear_inputs();
    rst_n = 0;
    m0_adr = 32'h100; m0_stb = 1; m0_cyc = 1; s_ack = 1; s_dat = 32'hFFFF_FFFF;
    @(negedge clk); #1;
    all_a = {a_s_adr, a_s_dat, a_s_we, a_s_sel, a_s_stb, a_s_cyc, a_m0_ack, a_m0_err,
             a_m0_dat, a_m1_ack, a_m1_err, a_m1_dat, a_grant};
    vec++; if (all_a !== '0) begin errs++; $display("FAIL reset_outputs got %h exp 0", all_a); end
    do_reset();
    s_ack = 1; s_dat = 32'h5555_AAAA;
    #1;
    vec++; if ({a_m0_ack, a_m1_ack, a_grant} !== 4'b0) begin errs++; $display("FAIL stray_ack got %b exp 0000", {a_m0_ack, a_m1_ack, a_grant}); end
    clear_inputs();
  endtask
  task automatic test_m0_read;
    logic bad;
    bad = 0;
    do_reset();
    @(negedge clk);
    m0_adr = 32'h100; m0_stb = 1; m0_cyc = 1; s_dat = 32'h1234_5678;
    #1;
    vec++; if ({a_grant, a_s_stb} !== 3'b000) begin errs++; $display("FAIL t1_idle_latency got %b exp 000", {a_grant, a_s_stb}); end
    @(negedge clk); #1;
    vec++; if ({a_grant, a_s_stb, a_s_we, a_s_sel} !== 8'b01_1_0_1111) begin errs++; $display("FAIL t1_grant0 got %b exp 01101111", {a_grant, a_s_stb, a_s_we, a_s_sel}); end
    vec++; if (a_s_adr !== 32'h100 || a_m0_dat !== 32'h0) begin errs++; $display("FAIL t1_adr_dat got %h/%h exp 00000100/00000000", a_s_adr, a_m0_dat); end
    repeat (68) begin @(negedge clk); #1; if (a_m0_ack | a_m0_err) bad = 1; end
    vec++; if (bad !== 1'b0) begin errs++; $display("FAIL t1_wait_noack got %b exp 0", bad); end
    @(negedge clk);
    s_ack = 1; s_dat = 32'hDEAD_BEEF;
    #1;
    vec++; if ({a_m0_ack, a_m0_err, a_s_stb, a_s_cyc} !== 4'b1000) begin errs++; $display("FAIL t1_ack got %b exp 1000", {a_m0_ack, a_m0_err, a_s_stb, a_s_cyc}); end
    vec++; if (a_m0_dat !== 32'hDEAD_BEEF) begin errs++; $display("FAIL t1_rdata got %h exp deadbeef", a_m0_dat); end
    @(negedge clk);
    clear_inputs();
    #1;
    vec++; if ({a_grant, a_m0_ack} !== 3'b000) begin errs++; $display("FAIL t1_done got %b exp 000", {a_grant, a_m0_ack}); end
  endtask
  task automatic test_priority;
    do_reset();
    @(negedge clk);
    m0_adr = 32'h100; m0_stb = 1; m0_cyc = 1;
    m1_adr = 32'h200; m1_stb = 1; m1_cyc = 1;
    @(negedge clk); #1;
    vec++; if (a_grant !== 2'b10 || a_s_adr !== 32'h200) begin errs++; $display("FAIL t2_first got %b/%h exp 10/00000200", a_grant, a_s_adr); end
    s_ack = 1; s_dat = 32'hCAFE_0001;
    #1;
    vec++; if ({a_m1_ack, a_m0_ack, a_m0_dat} !== {2'b10, 32'h0}) begin errs++; $display("FAIL t2_ack_owner got %b %b %h exp 1 0 0", a_m1_ack, a_m0_ack, a_m0_dat); end
    vec++; if (a_m1_dat !== 32'hCAFE_0001) begin errs++; $display("FAIL t2_m1_dat got %h exp cafe0001", a_m1_dat); end
    @(negedge clk);
    s_ack = 0; m1_stb = 0; m1_cyc = 0;
    #1;
    vec++; if (a_grant !== 2'b00) begin errs++; $display("FAIL t2_gap got %b exp 00", a_grant); end
    @(negedge clk); #1;
    vec++; if (a_grant !== 2'b01) begin errs++; $display("FAIL t2_second got %b exp 01", a_grant); end
    s_ack = 1;
    @(negedge clk);
    clear_inputs();
  endtask
  task automatic test_round_robin;
    logic [1:0] exp_g [4] = '{2'b01, 2'b10, 2'b01, 2'b10};
    do_reset();
    @(negedge clk);
    m0_stb = 1; m0_cyc = 1; m1_stb = 1; m1_cyc = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      vec++; if (b_grant !== exp_g[i]) begin errs++; $display("FAIL t3_order%0d got %b exp %b", i, b_grant, exp_g[i]); end
      s_ack = 1;
      @(negedge clk);
      s_ack = 0;
      #1;
      vec++; if (b_grant !== 2'b00) begin errs++; $display("FAIL t3_gap%0d got %b exp 00", i, b_grant); end
    end
    clear_inputs();
  endtask
  task automatic test_write;
    do_reset();
    @(negedge clk);
    m1_adr = 32'h300; m1_dat = 32'h0000_ABCD; m1_we = 1; m1_sel = 4'b0011; m1_stb = 1; m1_cyc = 1;
    @(negedge clk); #1;
    vec++; if ({a_grant, a_s_we, a_s_sel, a_s_stb} !== 8'b10_1_0011_1) begin errs++; $display("FAIL t4_ctrl got %b exp 10100111", {a_grant, a_s_we, a_s_sel, a_s_stb}); end
    vec++; if (a_s_dat !== 32'h0000_ABCD || a_s_adr !== 32'h300) begin errs++; $display("FAIL t4_data got %h/%h exp 0000abcd/00000300", a_s_dat, a_s_adr); end
    s_ack = 1;
    #1;
    vec++; if ({a_s_stb, a_s_cyc, a_m1_ack} !== 3'b001) begin errs++; $display("FAIL t4_ackcycle got %b exp 001", {a_s_stb, a_s_cyc, a_m1_ack}); end
    @(negedge clk);
    clear_inputs();
  endtask
  task automatic test_timeout;
    int first = 0;
    int pulses = 0;
    do_reset();
    @(negedge clk);
    m1_adr = 32'h400; m1_stb = 1; m1_cyc = 1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk); #1;
      if (b_m1_err) begin pulses++; if (first == 0) first = k; end
      if (b_m1_err) break;
    end
    vec++; if (first !== 16) begin errs++; $display("FAIL t5_err_cycle got %0d exp 16", first); end
    @(negedge clk);
    m1_stb = 0; m1_cyc = 0; m0_adr = 32'h500; m0_stb = 1; m0_cyc = 1;
    #1;
    vec++; if ({b_grant, b_m1_err, b_m1_ack} !== 4'b0000 || pulses !== 1) begin errs++; $display("FAIL t5_idle got %b pulses %0d exp 0000 1", {b_grant, b_m1_err, b_m1_ack}, pulses); end
    @(negedge clk); #1;
    vec++; if (b_grant !== 2'b01) begin errs++; $display("FAIL t5_m0_grant got %b exp 01", b_grant); end
    s_ack = 1; s_dat = 32'h0BAD_F00D;
    #1;
    vec++; if (b_m0_ack !== 1'b1 || b_m0_dat !== 32'h0BAD_F00D) begin errs++; $display("FAIL t5_m0_ack got %b/%h exp 1/0badf00d", b_m0_ack, b_m0_dat); end
    @(negedge clk);
    clear_inputs();
  endtask
  task automatic test_abort_and_reset;
    do_reset();
    @(negedge clk);
    m0_adr = 32'h600; m0_stb = 1; m0_cyc = 1;
    @(negedge clk); #1;
    vec++; if ({a_grant, a_s_stb} !== 3'b011) begin errs++; $display("FAIL t6_granted got %b exp 011", {a_grant, a_s_stb}); end
    m0_cyc = 0;
    #1;
    vec++; if ({a_s_stb, a_s_cyc, a_m0_ack, a_m0_err} !== 4'b0000) begin errs++; $display("FAIL t6_abort got %b exp 0000", {a_s_stb, a_s_cyc, a_m0_ack, a_m0_err}); end
    @(negedge clk); #1;
    vec++; if (a_grant !== 2'b00) begin errs++; $display("FAIL t6_abort_idle got %b exp 00", a_grant); end
    m0_cyc = 1;
    @(negedge clk); #1;
    vec++; if (a_grant !== 2'b01) begin errs++; $display("FAIL t6_regrant got %b exp 01", a_grant); end
    #1 rst_n = 0;
    s_ack = 1; s_dat = 32'h7777_7777;
    #1;
    vec++; if ({a_grant, a_s_stb, a_s_cyc, a_s_sel, a_m0_ack, a_m0_err} !== 10'b0) begin errs++; $display("FAIL t6_async_rst got %b exp 0", {a_grant, a_s_stb, a_s_cyc, a_s_sel, a_m0_ack, a_m0_err}); end
    vec++; if (a_s_adr !== 32'h0 || a_m0_dat !== 32'h0) begin errs++; $display("FAIL t6_rst_bus got %h/%h exp 0/0", a_s_adr, a_m0_dat); end
    do_reset();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired got running exp finished");
    $fatal(1, "bench timeout");
  end
  initial begin
    test_reset();
    test_m0_read();
    test_priority();
    test_round_robin();
    test_write();
    test_timeout();
    test_abort_and_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
